adaptive_thresh_hyst: RTL and testbench

//   Streaming per-pixel adaptive binariser for the preprocessing chain.

---
 rtl/adaptive_thresh_hyst.sv | 151 +++++++++++++++
 tb/tb_adaptive_thresh_hyst.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adaptive_thresh_hyst.sv
// adaptive_thresh_hyst
//   Streaming per-pixel adaptive binariser. It keeps a running exponential
//   mean of the pixel stream and flags pixels that sit beyond a runtime offset
//   from that mean. A hysteresis band decides when the flag releases. The mean
//   is reseeded on every start-of-frame, and decisions stay forced low for a
//   warm-up window of WARMUP valid pixels (the SOF pixel is index 0).
//
// Parameters
//   DW      pixel / mean / offset / hysteresis width
//   K       EMA shift; accumulator is DW+K bits, time constant 2^K pixels
//   WARMUP  valid pixels after SOF with decisions suppressed (>= 1)
//
// Ports
//   clk       clock
//   rst_n     synchronous active-low reset
//   i_vld     pixel valid; nothing advances while low
//   i_sof     start of frame, qualified by i_vld
//   i_pix     pixel value
//   i_mode    0 = flag bright, 1 = flag dark; latched on the SOF pixel
//   i_offset  threshold distance from the mean (live)
//   i_hyst    hysteresis band width (live)
//   o_vld     i_vld delayed by one cycle
//   o_flag    binarised decision for the pixel
//   o_mean    mean used for that pixel's decision
//   o_warm    1 while decisions are suppressed
module adaptive_thresh_hyst #(
    parameter int DW     = 8,
    parameter int K      = 8,
    parameter int WARMUP = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    input  logic          i_sof,
    input  logic [DW-1:0] i_pix,
    input  logic          i_mode,
    input  logic [DW-1:0] i_offset,
    input  logic [DW-1:0] i_hyst,
    output logic          o_vld,
    output logic          o_flag,
    output logic [DW-1:0] o_mean,
    output logic          o_warm
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WARM = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam int          CW     = $clog2(WARMUP + 1);
    localparam logic [CW-1:0] CNT_END = CW'(WARMUP);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    // A one-pixel warm-up means the SOF pixel alone is suppressed.
    localparam logic [1:0] S_AFTER_SOF = (WARMUP <= 1) ? S_RUN : S_WARM;

    logic [DW+K-1:0] r_acc;
    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_mode;
    logic            r_vld;
    logic            r_flag;
    logic [DW-1:0]   r_mean;
    logic            r_warm;

    logic [DW-1:0]   w_mean;
    logic [DW+K-1:0] w_acc_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [DW-1:0]   w_hi_b, w_lo_b, w_lo_d, w_hi_d;
    logic [DW-1:0]   w_hi, w_lo;
    logic            w_set, w_clr, w_flag_nxt;

    // Clamp a DW+2 bit two's-complement intermediate to [0, 2^DW-1].
    // Operands never exceed 2*(2^DW-1), so bit DW flags an overflow and
    // bit DW+1 flags a negative result.
    function automatic logic [DW-1:0] sat(input logic [DW+1:0] v);
        if (v[DW+1])
            return '0;
        else if (v[DW])
            return '1;
        else
            return v[DW-1:0];
    endfunction

    assign w_mean    = r_acc[DW+K-1:K];
    // acc >= mean<<K always holds, so this cannot wrap.
    assign w_acc_nxt = r_acc + {{K{1'b0}}, i_pix} - {{K{1'b0}}, w_mean};
    assign w_cnt_nxt = r_cnt + CNT_ONE;

    always_comb begin
        w_hi_b = sat({2'b00, w_mean} + {2'b00, i_offset});
        w_lo_b = sat({2'b00, w_hi_b} - {2'b00, i_hyst});
        w_lo_d = sat({2'b00, w_mean} - {2'b00, i_offset});
        w_hi_d = sat({2'b00, w_lo_d} + {2'b00, i_hyst});
        w_hi   = r_mode ? w_hi_d : w_hi_b;
        w_lo   = r_mode ? w_lo_d : w_lo_b;
        w_set  = r_mode ? (i_pix < w_lo) : (i_pix > w_hi);
        w_clr  = r_mode ? (i_pix > w_hi) : (i_pix < w_lo);
        w_flag_nxt = r_flag ? !w_clr : w_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_vld   <= 1'b0;
            r_flag  <= 1'b0;
            r_mean  <= '0;
            r_warm  <= 1'b1;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                if (i_sof) begin
                    r_acc   <= {i_pix, {K{1'b0}}};
                    r_state <= S_AFTER_SOF;
                    r_cnt   <= CNT_ONE;
                    r_mode  <= i_mode;
                    r_flag  <= 1'b0;
                    r_mean  <= i_pix;
                    r_warm  <= 1'b1;
                end else begin
                    r_acc  <= w_acc_nxt;
                    r_mean <= w_mean;
                    case (r_state)
                        S_RUN: begin
                            r_flag <= w_flag_nxt;
                            r_warm <= 1'b0;
                        end
                        S_WARM: begin
                            r_flag <= 1'b0;
                            r_warm <= 1'b1;
                            r_cnt  <= w_cnt_nxt;
                            if (w_cnt_nxt == CNT_END)
                                r_state <= S_RUN;
                        end
                        default: begin
                            r_flag <= 1'b0;
                            r_warm <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_flag = r_flag;
    assign o_mean = r_mean;
    assign o_warm = r_warm;

endmodule

// File: tb/tb_adaptive_thresh_hyst.sv
// Testbench for adaptive_thresh_hyst: directed scenarios followed by a
// randomized stream, all checked against an arithmetic reference model.
module tb_adaptive_thresh_hyst;

    localparam int DW     = 8;
    localparam int K      = 8;
    localparam int WARMUP = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_vld = 1'b0;
    logic          i_sof = 1'b0;
    logic [DW-1:0] i_pix = '0;
    logic          i_mode = 1'b0;
    logic [DW-1:0] i_offset = '0;
    logic [DW-1:0] i_hyst = '0;
    logic          o_vld, o_flag, o_warm;
    logic [DW-1:0] o_mean;

    adaptive_thresh_hyst #(.DW(DW), .K(K), .WARMUP(WARMUP)) dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_sof(i_sof),
        .i_pix(i_pix), .i_mode(i_mode), .i_offset(i_offset), .i_hyst(i_hyst),
        .o_vld(o_vld), .o_flag(o_flag), .o_mean(o_mean), .o_warm(o_warm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pixel index since SOF, integer accumulator.
    int m_acc = 0;
    int m_idx = 0;
    bit m_framed = 0;
    bit m_flag = 0;
    bit m_mode = 0;
    int e_vld = 0, e_flag = 0, e_mean = 0, e_warm = 1;

    logic          cur_mode = 0;
    logic [DW-1:0] cur_off = 8'd8;
    logic [DW-1:0] cur_hyst = 8'd4;

    function automatic int clamp(input int v);
        int mx = (1 << DW) - 1;
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int p, mean, hi, lo, off, hy;
        p   = int'(i_pix);
        off = int'(i_offset);
        hy  = int'(i_hyst);
        if (!rst_n) begin
            m_acc = 0; m_idx = 0; m_framed = 0; m_flag = 0; m_mode = 0;
            e_vld = 0; e_flag = 0; e_mean = 0; e_warm = 1;
        end else if (i_vld) begin
            e_vld = 1;
            if (i_sof) begin
                m_acc = p * (1 << K);
                m_framed = 1; m_idx = 1; m_mode = i_mode; m_flag = 0;
                e_mean = p; e_warm = 1;
            end else begin
                mean = m_acc / (1 << K);
                e_mean = mean;
                if (m_framed && m_idx >= WARMUP) begin
                    if (!m_mode) begin
                        hi = clamp(mean + off);
                        lo = clamp(hi - hy);
                        if (!m_flag && p > hi) m_flag = 1;
                        else if (m_flag && p < lo) m_flag = 0;
                    end else begin
                        lo = clamp(mean - off);
                        hi = clamp(lo + hy);
                        if (!m_flag && p < lo) m_flag = 1;
                        else if (m_flag && p > hi) m_flag = 0;
                    end
                    e_warm = 0;
                end else begin
                    m_flag = 0;
                    e_warm = 1;
                end
                m_acc = m_acc + p - mean;
                if (m_framed && m_idx < WARMUP) m_idx++;
            end
            e_flag = m_flag;
        end else begin
            e_vld = 0;
        end
    endtask

    task automatic step(input logic rn, input logic v, input logic s,
                        input logic [DW-1:0] p, input logic m,
                        input logic [DW-1:0] o, input logic [DW-1:0] h,
                        input string tag);
        rst_n = rn; i_vld = v; i_sof = s; i_pix = p;
        i_mode = m; i_offset = o; i_hyst = h;
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".vld"},  32'(o_vld),  32'(e_vld));
        check({tag, ".flag"}, 32'(o_flag), 32'(e_flag));
        check({tag, ".mean"}, 32'(o_mean), 32'(e_mean));
        check({tag, ".warm"}, 32'(o_warm), 32'(e_warm));
    endtask

    task automatic pix(input logic [DW-1:0] p, input string tag);
        step(1'b1, 1'b1, 1'b0, p, cur_mode, cur_off, cur_hyst, tag);
    endtask

    task automatic sof(input logic [DW-1:0] p, input logic m, input string tag);
        step(1'b1, 1'b1, 1'b1, p, m, cur_off, cur_hyst, tag);
    endtask

    logic [DW-1:0] seq_pix [5];
    bit            seq_flg [5];
    int            prev_mean;

    initial begin
        // Reset state.
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, "rst");
        step(1'b0, 1'b1, 1'b1, 8'd77, 1'b1, 8'd0, 8'd0, "rst_prio");
        check("rst_warm", 32'(o_warm), 32'd1);
        check("rst_mean", 32'(o_mean), 32'd0);

        // 1: warm-up window on a flat 100 stream (bright mode).
        cur_mode = 0; cur_off = 8'd8; cur_hyst = 8'd4;
        sof(8'd100, 1'b0, "t1_sof");
        check("t1_warm0", 32'(o_warm), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            pix(8'd100, "t1");
            check("t1_warm", 32'(o_warm), (i < WARMUP) ? 32'd1 : 32'd0);
            check("t1_flag", 32'(o_flag), 32'd0);
            check("t1_mean", 32'(o_mean), 32'd100);
        end

        // 2: bright with hysteresis.
        seq_pix = '{8'd108, 8'd109, 8'd105, 8'd104, 8'd103};
        seq_flg = '{0, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            pix(seq_pix[i], "t2");
            check("t2_const", 32'(o_flag), 32'(seq_flg[i]));
        end

        // 3: dark with hysteresis; background 101 keeps the mean at 100.
        sof(8'd100, 1'b1, "t3_sof");
        for (int i = 0; i < 40; i++) pix(8'd101, "t3_warm");
        seq_pix = '{8'd92, 8'd91, 8'd95, 8'd96, 8'd97};
        for (int i = 0; i < 5; i++) begin
            pix(seq_pix[i], "t3");
            check("t3_const", 32'(o_flag), 32'(seq_flg[i]));
        end
        cur_mode = 1'b0;
        pix(8'd80, "t3_modechg");
        check("t3_mode_ignored", 32'(o_flag), 32'd1);

        // 4: saturated thresholds never set the flag.
        sof(8'd250, 1'b0, "t4b_sof");
        for (int i = 0; i < 20; i++) pix(8'd250, "t4b_warm");
        pix(8'd255, "t4b");
        check("t4_hi_sat", 32'(o_flag), 32'd0);
        sof(8'd3, 1'b1, "t4d_sof");
        for (int i = 0; i < 20; i++) pix(8'd3, "t4d_warm");
        pix(8'd0, "t4d");
        check("t4_lo_sat", 32'(o_flag), 32'd0);

        // 5: step response with random valid gaps.
        sof(8'd100, 1'b0, "t5_sof");
        prev_mean = 100;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) begin
                step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, cur_off, cur_hyst, "t5_gap");
            end else begin
                pix(8'd200, "t5");
                check("t5_monotone",
                      32'(int'(o_mean) >= prev_mean && int'(o_mean) <= 200), 32'd1);
                prev_mean = int'(o_mean);
            end
        end

        // 6: SOF in RUN with flag set, then a mid-frame reset.
        sof(8'd100, 1'b0, "t6_sof");
        for (int i = 0; i < 20; i++) pix(8'd100, "t6_warm");
        pix(8'd120, "t6_set");
        check("t6_flag_set", 32'(o_flag), 32'd1);
        sof(8'd120, 1'b0, "t6_resof");
        for (int i = 1; i < WARMUP; i++) begin
            pix(8'd140, "t6_rewarm");
            check("t6_rewarm_w", 32'(o_warm), 32'd1);
        end
        pix(8'd140, "t6_run");
        check("t6_run_w", 32'(o_warm), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'd200, 1'b0, cur_off, cur_hyst, "t6_rst");
        check("t6_rst_vld", 32'(o_vld), 32'd0);
        check("t6_rst_flag", 32'(o_flag), 32'd0);
        for (int i = 0; i < 30; i++) begin
            pix(8'd255, "t6_idle");
            check("t6_idle_w", 32'(o_warm), 32'd1);
        end

        // Randomized stream.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(299) != 0), ($urandom_range(3) != 0),
                 ($urandom_range(79) == 0), 8'($urandom), 1'($urandom),
                 8'($urandom_range(40)), 8'($urandom_range(15)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
